// File: rtl/peak_picker.sv
`default_nettype none
// ============================================================================
//  Module   : peak_picker
//  Purpose  : Streaming spectrogram peak picker. Buffers three magnitude frames
//             and scans the middle one for 4-neighbour local maxima. Optional
//             magnitude floor via macro PEAK_PICKER_THRESH_EN (adds `thresh`).
//  Revision : 1.0 - initial release
// ============================================================================
module peak_picker #(
    parameter int AMPL_WIDTH = 24,
    parameter int FREQS      = 256,
    parameter int MAX_PEAKS  = 8,
    parameter int FREQ_WIDTH = $clog2(FREQS)
) (
    input  logic                             CLOCK_50,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [AMPL_WIDTH-1:0]            in_ampl,
`ifdef PEAK_PICKER_THRESH_EN
    input  logic [AMPL_WIDTH-1:0]            thresh,
`endif
    output logic                             peak_valid,
    input  logic                             peak_ready,
    output logic [FREQ_WIDTH-1:0]            peak_freq,
    output logic [AMPL_WIDTH-1:0]            peak_ampl,
    output logic                             frame_done,
    output logic [$clog2(MAX_PEAKS+1)-1:0]   peak_count
);

    localparam int                    c_CNT_W     = $clog2(MAX_PEAKS + 1);
    localparam logic [1:0]            c_ST_FILL   = 2'd0;
    localparam logic [1:0]            c_ST_SCAN   = 2'd1;
    localparam logic [1:0]            c_ST_DONE   = 2'd2;
    localparam logic [FREQ_WIDTH-1:0] c_LAST_BIN  = FREQ_WIDTH'(FREQS - 1);
    localparam logic [c_CNT_W-1:0]    c_LAST_PEAK = c_CNT_W'(MAX_PEAKS - 1);

    logic [1:0]            r_state, w_state_nx;
    logic [AMPL_WIDTH-1:0] r_bank [0:2][0:FREQS-1];
    logic [1:0]            r_wr_ptr, r_frame_cnt;
    logic [FREQ_WIDTH-1:0] r_bin, r_k, w_k_dn, w_k_up;
    logic [c_CNT_W-1:0]    r_emit, r_peak_count;
    logic                  r_peak_valid;
    logic [FREQ_WIDTH-1:0] r_peak_freq;
    logic [AMPL_WIDTH-1:0] r_peak_ampl;
    logic [1:0]            w_prev_sel, w_curr_sel, w_next_sel;
    logic [AMPL_WIDTH-1:0] w_curr, w_north, w_south, w_prev, w_next;
    logic                  w_in_hs, w_adv, w_thresh_ok, w_found, w_scan_end;

    assign in_ready   = reset_n && (r_state == c_ST_FILL);
    assign w_in_hs    = in_valid && in_ready;
    assign peak_valid = r_peak_valid;
    assign peak_freq  = r_peak_freq;
    assign peak_ampl  = r_peak_ampl;
    assign frame_done = (r_state == c_ST_DONE) && !r_peak_valid;
    assign peak_count = frame_done ? r_emit : r_peak_count;

    // The write pointer sits on the oldest bank, so prev is the bank about to be overwritten.
    always_comb begin
        w_prev_sel = 2'd0;
        w_curr_sel = 2'd1;
        w_next_sel = 2'd2;
        case (r_wr_ptr)
            2'd1:    begin w_prev_sel = 2'd1; w_curr_sel = 2'd2; w_next_sel = 2'd0; end
            2'd2:    begin w_prev_sel = 2'd2; w_curr_sel = 2'd0; w_next_sel = 2'd1; end
            default: begin w_prev_sel = 2'd0; w_curr_sel = 2'd1; w_next_sel = 2'd2; end
        endcase
    end

    assign w_k_dn = r_k - FREQ_WIDTH'(1);
    assign w_k_up = r_k + FREQ_WIDTH'(1);

    always_comb begin
        w_curr  = r_bank[w_curr_sel][r_k];
        w_prev  = r_bank[w_prev_sel][r_k];
        w_next  = r_bank[w_next_sel][r_k];
        w_north = '0;
        w_south = '0;
        if (r_k != '0)
            w_north = r_bank[w_curr_sel][w_k_dn];
        if (r_k != c_LAST_BIN)
            w_south = r_bank[w_curr_sel][w_k_up];
    end

`ifdef PEAK_PICKER_THRESH_EN
    assign w_thresh_ok = (w_curr >= thresh);
`else
    assign w_thresh_ok = 1'b1;
`endif

    assign w_adv      = (r_state == c_ST_SCAN) && (!r_peak_valid || peak_ready);
    assign w_found    = w_adv && w_thresh_ok && (w_curr >= w_north) && (w_curr >= w_south)
                        && (w_curr >= w_prev) && (w_curr >= w_next);
    assign w_scan_end = w_adv && ((r_k == c_LAST_BIN) || (w_found && (r_emit == c_LAST_PEAK)));

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n)
            r_state <= c_ST_FILL;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_ST_FILL: if (w_in_hs && (r_bin == c_LAST_BIN) && (r_frame_cnt >= 2'd2))
                           w_state_nx = c_ST_SCAN;
            c_ST_SCAN: if (w_scan_end)
                           w_state_nx = c_ST_DONE;
            c_ST_DONE: if (!r_peak_valid)
                           w_state_nx = c_ST_FILL;
            default:   w_state_nx = c_ST_FILL;
        endcase
    end

    // Bank contents are deliberately left unreset; the frame counter guards stale data.
    always_ff @(posedge CLOCK_50) begin
        if (w_in_hs)
            r_bank[r_wr_ptr][r_bin] <= in_ampl;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_bin        <= '0;
            r_wr_ptr     <= 2'd0;
            r_frame_cnt  <= 2'd0;
            r_k          <= '0;
            r_emit       <= '0;
            r_peak_count <= '0;
            r_peak_valid <= 1'b0;
            r_peak_freq  <= '0;
            r_peak_ampl  <= '0;
        end else begin
            if (w_in_hs) begin
                if (r_bin == c_LAST_BIN) begin
                    r_bin    <= '0;
                    r_wr_ptr <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
                    if (r_frame_cnt != 2'd3)
                        r_frame_cnt <= r_frame_cnt + 2'd1;
                end else begin
                    r_bin <= r_bin + FREQ_WIDTH'(1);
                end
            end
            if (r_peak_valid && peak_ready)
                r_peak_valid <= 1'b0;
            if (w_adv)
                r_k <= w_scan_end ? '0 : w_k_up;
            if (w_found) begin
                r_peak_valid <= 1'b1;
                r_peak_freq  <= r_k;
                r_peak_ampl  <= w_curr;
                r_emit       <= r_emit + c_CNT_W'(1);
            end
            if (frame_done) begin
                r_peak_count <= r_emit;
                r_emit       <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/peak_picker.md
# peak_picker

Streaming spectrogram peak picker for the fingerprinting path. It accepts FFT magnitude frames one bin per beat into a three-frame rotating buffer (previous, current, next). Once a full new frame has arrived, it scans the middle frame for local maxima against four neighbours and emits up to `MAX_PEAKS` (frequency, amplitude) pairs per frame on a valid/ready stream. It sits between the FFT magnitude stage and the hash/pairing stage.

## Interface
- `AMPL_WIDTH`, default 24: magnitude bit width.
- `FREQS`, default 256: bins per frame; must be ≥2.
- `MAX_PEAKS`, default 8: peaks emitted per frame; ≥1.
- `FREQ_WIDTH`, default `$clog2(FREQS)`: derived; do not override.
- `CLOCK_50`  in  1: sole clock, rising edge.
- `reset_n`  in  1: synchronous active-low reset. One clock; reset is synchronous and active-low.
- `in_valid`  in  1: input bin valid.
- `in_ready`  out  1: block accepts a bin.
- `in_ampl`  in  `AMPL_WIDTH`: bin magnitude. Bins arrive in order 0..`FREQS-1`.
- `peak_valid`  out  1: output peak valid.
- `peak_ready`  in  1: consumer accepts the peak.
- `peak_freq`  out  `FREQ_WIDTH`: bin index of the peak.
- `peak_ampl`  out  `AMPL_WIDTH`: peak magnitude.
- `frame_done`  out  1: one-cycle pulse when a scan finishes.
- `peak_count`  out  `$clog2(MAX_PEAKS+1)`: peaks emitted in the last scan; valid with `frame_done` and held until the next pulse.

## Operation
- Storage: three banks of `FREQS`×`AMPL_WIDTH` registers.
  - A 2-bit write pointer selects the bank being filled.
  - At the end of each frame the roles rotate mod 3: the written bank becomes "next", the old "next" becomes "curr", and the old "curr" becomes "prev".
- States: FILL, SCAN, DONE.
- FILL:
  - `in_ready`=1.
  - A bin counter increments on each `in_valid&&in_ready` handshake.
  - On the `FREQS`-th beat the counter wraps to 0, the banks rotate, and a saturating frame counter (0..3) increments.
  - If the frame counter is now ≥3, go to SCAN; otherwise stay in FILL.
- SCAN:
  - `in_ready`=0.
  - Scan index k runs 0..`FREQS-1` and advances only when `!peak_valid || peak_ready`.
  - Bin k is a peak iff curr[k] ≥ north, south, prev[k] and next[k].
    - north = curr[k-1], or 0 when k=0.
    - south = curr[k+1], or 0 when k=`FREQS-1`.
    - Comparisons are unsigned; ties count as peaks.
  - When a peak is found, load `peak_freq`=k and `peak_ampl`=curr[k], set `peak_valid`, and increment the emitted count.
  - Go to DONE after bin `FREQS-1` is evaluated, or immediately when the emitted count reaches `MAX_PEAKS` (early exit).
- DONE:
  - Wait until `peak_valid`=0, i.e. the last peak has been consumed.
  - Then pulse `frame_done`, latch `peak_count`, clear the emitted count, and go to FILL.
- Reset mid-operation:
  - State returns to FILL; bin counter, frame counter and write pointer clear to 0.
  - Bank contents are not cleared. This is safe because the frame counter forces three fresh frames before any scan.
  - Any partial frame or in-flight peak is discarded.

## Timing
- Reset values: `in_ready`=0 while `reset_n`=0, and 1 in the first cycle after release. `peak_valid`=0, `peak_freq`=0, `peak_ampl`=0, `frame_done`=0, `peak_count`=0.
- The final input beat of a frame in cycle c puts the block in SCAN in cycle c+1, with `in_ready`=0 in c+1.
- Bin k evaluated in cycle s gives `peak_valid` in cycle s+1 (registered output).
- With `peak_ready` held at 1, a scan takes exactly `FREQS` cycles (fewer on early exit). DONE then takes 1 cycle plus any stall.
- `frame_done` asserts 1 cycle after the last peak handshake, or 1 cycle after entering DONE if no peak is pending. FILL (`in_ready`=1) follows in the next cycle.
- `peak_freq`/`peak_ampl` are stable while `peak_valid && !peak_ready`.
- A peak handshake and a new peak load in the same cycle give back-to-back peaks with no bubble.
- First scan latency: after the third complete frame. Thereafter every frame triggers a scan.

## Configuration
- `PEAK_PICKER_THRESH_EN`
  - Defined: adds input port `thresh` (`AMPL_WIDTH`, sampled each scan cycle). A bin is a peak only if it satisfies the neighbour test and curr[k] ≥ `thresh`.
  - Undefined: no `thresh` port; the neighbour test alone decides.

## Test plan
Bench configuration for all tests: `FREQS`=8, `AMPL_WIDTH`=8, `MAX_PEAKS`=4.

- **Single peak:** prev=next=all 10; curr=all 5 except bin 3=50; `peak_ready`=1 → one peak (freq 3, ampl 50), then `frame_done` with `peak_count`=1.
- **Edges and cap:** curr bins 0 and 7=40, rest 5, neighbours 10 → peaks at freq 0 then 7. Then all-zero frames → peaks at freq 0,1,2,3 (ampl 0), early exit, `peak_count`=4.
- **Backpressure:** single-peak stimulus with `peak_ready`=0 for 5 cycles → (3,50) held stable with `peak_valid`=1; no lost or duplicated peak; `frame_done` follows the handshake by 1 cycle.
- **Warm-up:** two frames sent → no `peak_valid` and no `frame_done`; the third frame → scan of frame 2 begins the next cycle with `in_ready`=0.
- **Mid-scan reset:** `reset_n`=0 for 1 cycle during SCAN → `peak_valid`=0 and `in_ready`=1 the cycle after release; three new frames are needed before the next output.
- **Threshold (macro defined):** `thresh`=20 with all-zero frames → no peaks, `frame_done` with `peak_count`=0.
